hazard_interlock: RTL and testbench
===================================

Name: hazard_interlock

Overview:
- Stall/flush controller for the 5-stage pipeline; resolves the hazards that operand forwarding cannot.
- Detects load-use hazards between F/D and D/X and inserts a one-cycle bubble.
- Sequences multi-cycle mul/div through the multdiv unit, freezing the front of the pipe until the result is ready.
- Flushes wrong-path instructions on taken branches and jumps resolved in X. Keeps a saturating stall-cycle counter.

Parameters:
- MD_TIMEOUT, 40: max cycles in MD_WAIT before md_error is raised and the FSM is forced back to IDLE.
- CNT_W, 32: width of stall_cycles.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- IR_D  in  32  instruction in the F/D latch.
- IR_X  in  32  instruction in the D/X latch.
- branch_taken  in  1  X-stage branch/jump redirect (bne/blt taken, j, jal, jr, bex taken).
- md_ready  in  1  multdiv data_resultRDY.
- stall_FD  out  1  hold PC and F/D latch.
- stall_DX  out  1  hold D/X latch.
- bubble_DX  out  1  load nop into D/X.
- bubble_XM  out  1  load nop into X/M.
- flush_FD  out  1  load nop into F/D.
- md_start  out  1  one-cycle ctrlMULT/ctrlDIV launch pulse.
- md_is_div  out  1  qualifies md_start: 1 = div, 0 = mul.
- md_busy  out  1  FSM is in MD_WAIT.
- md_error  out  1  sticky; timeout occurred.
- stall_cycles  out  CNT_W  saturating count of cycles with stall_FD=1.

Behaviour:
- Decode fields:
  - opcode = [31:27], Rd = [26:22], Rs = [21:17], Rt = [16:12], ALUop = [6:2].
  - lw = 01000, sw = 00111, R-type = 00000.
  - mul = R-type with ALUop 00110; div = R-type with ALUop 00111.
- Sources read by D:
  - R-type: Rs, Rt.
  - I-type ALU, lw: Rs.
  - sw: Rs (address), Rd (data).
  - bne, blt: Rd, Rs.
  - jr: Rd.
  - bex: r30.
  - j, jal, setx: none.
- Register 0 never causes a hazard.
- load_use = IR_X is lw, lw.Rd != 0, and lw.Rd matches any source of IR_D.
  - Exception: D is sw and the only match is sw's data register (Rd). No stall; the data is forwarded W->M.
- FSM states: IDLE, MD_WAIT.
- IDLE:
  - If IR_X is mul/div: md_start=1 and md_is_div set for that cycle; next state MD_WAIT; timeout counter cleared.
  - Otherwise remain in IDLE.
- MD_WAIT:
  - stall_FD=1, stall_DX=1, bubble_XM=1, md_busy=1.
  - Timeout counter increments each cycle.
  - md_ready=1: next state IDLE; stalls drop combinationally that same cycle, so the mul/div advances to M on the next edge.
  - Counter reaches MD_TIMEOUT without md_ready: set md_error (sticky until reset), go to IDLE.
- md_start is registered-exclusive: it asserts only on the IDLE->MD_WAIT transition, never twice for one instruction.
- Combinational outputs, priority high to low:
  1. branch_taken (IDLE only): flush_FD=1, bubble_DX=1, stall_FD=0. Overrides load_use.
  2. MD_WAIT: the stall set above. branch_taken is ignored, because X is frozen.
  3. load_use: stall_FD=1, bubble_DX=1.
  4. Otherwise: all 0.
- mul/div in X together with branch_taken in the same cycle is impossible by ISA; if it occurs, md_start takes precedence and no flush is issued.
- stall_cycles increments each cycle stall_FD=1 and saturates at all-ones.
- Reset (asynchronous, any time including mid-MD_WAIT):
  - State IDLE, timeout counter 0, md_error 0, stall_cycles 0.
  - All outputs 0.
  - Any multdiv result in flight is abandoned; md_ready is ignored while in IDLE.

Test Plan:
- IR_X = lw r5,0(r2); IR_D = add r7,r5,r3 -> stall_FD=1, bubble_DX=1 for exactly 1 cycle; stall_cycles=1.
- IR_X = lw r5; IR_D = sw r5,4(r6) (data only) -> no stall. IR_D = sw r1,0(r5) -> 1-cycle stall. lw r0 -> never stalls.
- IR_X = mul r4,r1,r2; md_ready asserted 17 cycles later -> md_start=1 for 1 cycle, md_is_div=0; stall_FD/stall_DX/bubble_XM=1 for 17 cycles, all 0 on the md_ready cycle; stall_cycles=17.
- IR_X = div, md_ready never asserted -> md_error=1 after 40 cycles in MD_WAIT; FSM returns to IDLE; md_error stays 1.
- branch_taken=1 while load_use is true -> flush_FD=1, bubble_DX=1, stall_FD=0.
- reset_n pulled low at cycle 5 of MD_WAIT, asynchronous to clock -> all outputs 0 immediately; after release, state is IDLE and md_ready=1 produces no effect.

Source files
------------

// File: rtl/hazard_interlock_if.sv
// Pipeline-to-interlock signal bundle: instruction latches and multdiv status in,
// stall/bubble/flush controls and multdiv sequencing out.
interface hazard_interlock_if;
  logic [31:0] IR_D;
  logic [31:0] IR_X;
  logic        branch_taken;
  logic        md_ready;
  logic        stall_FD;
  logic        stall_DX;
  logic        bubble_DX;
  logic        bubble_XM;
  logic        flush_FD;
  logic        md_start;
  logic        md_is_div;
  logic        md_busy;
  logic        md_error;

  modport master (
    output IR_D, IR_X, branch_taken, md_ready,
    input  stall_FD, stall_DX, bubble_DX, bubble_XM, flush_FD,
           md_start, md_is_div, md_busy, md_error
  );

  modport slave (
    input  IR_D, IR_X, branch_taken, md_ready,
    output stall_FD, stall_DX, bubble_DX, bubble_XM, flush_FD,
           md_start, md_is_div, md_busy, md_error
  );
endinterface

// File: rtl/hazard_interlock.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, mul/div
// sequencing with timeout, branch flushes and a saturating stall-cycle counter.
module hazard_interlock #(
  parameter int unsigned MD_TIMEOUT = 40,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  hazard_interlock_if.slave hz,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned TO_W = $clog2(MD_TIMEOUT + 1);

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_BEX  = 5'b10110;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  typedef enum logic {IDLE, MD_WAIT} state_t;

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic            md_error_q;

  logic stall_fd_c, stall_dx_c, bubble_dx_c, bubble_xm_c, flush_fd_c;
  logic md_start_c, md_is_div_c, md_busy_c;
  logic md_in_x, load_use;
  logic unused_ir;

  // sw data (Rd) is deliberately not a source here: it is forwarded W->M.
  function automatic logic reads_reg(input logic [31:0] ir, input logic [4:0] r);
    logic [4:0] op, rd, rs, rt;
    op = ir[31:27];
    rd = ir[26:22];
    rs = ir[21:17];
    rt = ir[16:12];
    case (op)
      OP_R:             reads_reg = (rs == r) || (rt == r);
      OP_ADDI, OP_LW:   reads_reg = (rs == r);
      OP_SW:            reads_reg = (rs == r);
      OP_BNE, OP_BLT:   reads_reg = (rd == r) || (rs == r);
      OP_JR:            reads_reg = (rd == r);
      OP_BEX:           reads_reg = (r == 5'd30);
      default:          reads_reg = 1'b0;
    endcase
  endfunction

  assign unused_ir = ^{hz.IR_X[21:7], hz.IR_X[1:0], hz.IR_D[11:0]};

  always_comb begin
    md_in_x  = (hz.IR_X[31:27] == OP_R) &&
               ((hz.IR_X[6:2] == ALU_MUL) || (hz.IR_X[6:2] == ALU_DIV));
    load_use = (hz.IR_X[31:27] == OP_LW) && (hz.IR_X[26:22] != 5'd0) &&
               reads_reg(hz.IR_D, hz.IR_X[26:22]);
  end

  always_comb begin
    stall_fd_c  = 1'b0;
    stall_dx_c  = 1'b0;
    bubble_dx_c = 1'b0;
    bubble_xm_c = 1'b0;
    flush_fd_c  = 1'b0;
    md_start_c  = 1'b0;
    md_is_div_c = 1'b0;
    md_busy_c   = 1'b0;
    if (state == MD_WAIT) begin
      md_busy_c = 1'b1;
      // md_ready releases the freeze in the same cycle so the result advances on the next edge.
      if (!hz.md_ready) begin
        stall_fd_c  = 1'b1;
        stall_dx_c  = 1'b1;
        bubble_xm_c = 1'b1;
      end
    end else if (md_in_x) begin
      md_start_c  = 1'b1;
      md_is_div_c = (hz.IR_X[6:2] == ALU_DIV);
    end else if (hz.branch_taken) begin
      flush_fd_c  = 1'b1;
      bubble_dx_c = 1'b1;
    end else if (load_use) begin
      stall_fd_c  = 1'b1;
      bubble_dx_c = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      to_cnt       <= '0;
      md_error_q   <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (stall_fd_c && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      case (state)
        IDLE: begin
          if (md_in_x) begin
            state  <= MD_WAIT;
            to_cnt <= '0;
          end
        end
        MD_WAIT: begin
          if (hz.md_ready) begin
            state <= IDLE;
          end else if (to_cnt == TO_W'(MD_TIMEOUT - 1)) begin
            md_error_q <= 1'b1;
            state      <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are forced low while reset is held, independent of the clock.
  assign hz.stall_FD  = reset_n & stall_fd_c;
  assign hz.stall_DX  = reset_n & stall_dx_c;
  assign hz.bubble_DX = reset_n & bubble_dx_c;
  assign hz.bubble_XM = reset_n & bubble_xm_c;
  assign hz.flush_FD  = reset_n & flush_fd_c;
  assign hz.md_start  = reset_n & md_start_c;
  assign hz.md_is_div = reset_n & md_is_div_c;
  assign hz.md_busy   = reset_n & md_busy_c;
  assign hz.md_error  = reset_n & md_error_q;

endmodule

// File: tb/tb_hazard_interlock.sv
// Directed-vector bench for hazard_interlock: load-use, sw exception, branch
// priority, mul/div sequencing, timeout, counter saturation and async reset.
module tb_hazard_interlock;

  localparam int unsigned CW = 6;

  logic          clock;
  logic          reset_n;
  logic [CW-1:0] stall_cycles;
  int            vectors;
  int            miscompares;
  int            exp_stall;

  hazard_interlock_if hz ();

  hazard_interlock #(.MD_TIMEOUT(40), .CNT_W(CW)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .hz           (hz),
    .stall_cycles (stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [8:0] B_SFD  = 9'b100000000;
  localparam logic [8:0] B_SDX  = 9'b010000000;
  localparam logic [8:0] B_BDX  = 9'b001000000;
  localparam logic [8:0] B_BXM  = 9'b000100000;
  localparam logic [8:0] B_FL   = 9'b000010000;
  localparam logic [8:0] B_ST   = 9'b000001000;
  localparam logic [8:0] B_DIV  = 9'b000000100;
  localparam logic [8:0] B_BUSY = 9'b000000010;
  localparam logic [8:0] B_ERR  = 9'b000000001;
  localparam logic [8:0] WAITSET = B_SFD | B_SDX | B_BXM | B_BUSY;
  localparam logic [8:0] LUSE    = B_SFD | B_BDX;

  function automatic logic [31:0] r_op(input logic [4:0] rd, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] alu);
    return {5'b00000, rd, rs, rt, 5'd0, alu, 2'b00};
  endfunction

  function automatic logic [31:0] i_op(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  logic [31:0] NOP, LW5, LW0, LW30, LW9, ADD753, ADD705, SW_DATA, SW_ADDR;
  logic [31:0] BEX, JAL9, JR9, MUL, DIV, ADD741;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] ir_x, input logic [31:0] ir_d,
                       input logic br, input logic rdy);
    hz.IR_X         = ir_x;
    hz.IR_D         = ir_d;
    hz.branch_taken = br;
    hz.md_ready     = rdy;
    #1;
  endtask

  task automatic chk(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = {hz.stall_FD, hz.stall_DX, hz.bubble_DX, hz.bubble_XM, hz.flush_FD,
           hz.md_start, hz.md_is_div, hz.md_busy, hz.md_error};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%b expected=%b (SFD SDX BDX BXM FL ST DIV BUSY ERR)",
             tag, obs, exp);
    end
    if (exp[8] && exp_stall < 63) exp_stall++;
  endtask

  task automatic chk_cnt(input string tag);
    vectors++;
    assert (stall_cycles === CW'(exp_stall)) else begin
      miscompares++;
      $error("FAIL %s: stall_cycles observed=%0d expected=%0d", tag, stall_cycles, exp_stall);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_stall   = 0;
    NOP     = 32'd0;
    LW5     = i_op(5'b01000, 5'd5, 5'd2, 17'd0);
    LW0     = i_op(5'b01000, 5'd0, 5'd2, 17'd0);
    LW30    = i_op(5'b01000, 5'd30, 5'd2, 17'd0);
    LW9     = i_op(5'b01000, 5'd9, 5'd2, 17'd0);
    ADD753  = r_op(5'd7, 5'd5, 5'd3, 5'd0);
    ADD705  = r_op(5'd7, 5'd0, 5'd0, 5'd0);
    SW_DATA = i_op(5'b00111, 5'd5, 5'd6, 17'd4);
    SW_ADDR = i_op(5'b00111, 5'd1, 5'd5, 17'd0);
    BEX     = {5'b10110, 27'd0};
    JAL9    = {5'b00011, 5'd9, 5'd9, 17'd0};
    JR9     = {5'b00100, 5'd9, 22'd0};
    MUL     = r_op(5'd4, 5'd1, 5'd2, 5'b00110);
    DIV     = r_op(5'd4, 5'd1, 5'd2, 5'b00111);
    ADD741  = r_op(5'd7, 5'd4, 5'd1, 5'd0);

    hz.IR_X = '0; hz.IR_D = '0; hz.branch_taken = 1'b0; hz.md_ready = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("reset_outs", '0);
    chk_cnt("reset_cnt");
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;

    // load-use cases
    tick(); drive(LW5, ADD753, 0, 0);   chk("lu_add", LUSE);
    tick(); drive(NOP, ADD753, 0, 0);   chk("lu_add_once", '0);
    tick(); drive(LW5, SW_DATA, 0, 0);  chk("lu_sw_data", '0);
    tick(); drive(LW5, SW_ADDR, 0, 0);  chk("lu_sw_addr", LUSE);
    tick(); drive(NOP, SW_ADDR, 0, 0);  chk("lu_sw_once", '0);
    chk_cnt("cnt_lu");
    tick(); drive(LW0, ADD705, 0, 0);   chk("lu_r0", '0);
    tick(); drive(LW30, BEX, 0, 0);     chk("lu_bex_r30", LUSE);
    tick(); drive(LW9, JAL9, 0, 0);     chk("lu_jal_none", '0);
    tick(); drive(LW9, JR9, 0, 0);      chk("lu_jr", LUSE);
    tick(); drive(LW5, ADD753, 1, 0);   chk("br_over_lu", B_FL | B_BDX);
    tick(); drive(NOP, NOP, 0, 0);      chk("br_done", '0);
    chk_cnt("cnt_pre_mul");

    // mul with md_ready after 17 wait cycles
    tick(); drive(MUL, ADD741, 0, 0);   chk("mul_launch", B_ST);
    for (int i = 0; i < 17; i++) begin
      tick(); drive(MUL, ADD741, 0, 0); chk("mul_wait", WAITSET);
    end
    tick(); drive(MUL, ADD741, 0, 1);   chk("mul_ready", B_BUSY);
    tick(); drive(ADD741, NOP, 0, 0);   chk("mul_done", '0);
    chk_cnt("cnt_mul");

    // mul and branch together: launch wins, no flush
    tick(); drive(MUL, NOP, 1, 0);      chk("mul_vs_branch", B_ST);
    tick(); drive(MUL, NOP, 0, 1);      chk("mul_fast_ready", B_BUSY);
    tick(); drive(NOP, NOP, 0, 0);      chk("mul_fast_done", '0);

    // div never completes: timeout after 40 wait cycles, branch ignored while waiting
    tick(); drive(DIV, NOP, 0, 0);      chk("div_launch", B_ST | B_DIV);
    for (int i = 0; i < 40; i++) begin
      tick(); drive(DIV, NOP, (i == 5), 0); chk("div_wait", WAITSET);
    end
    tick(); drive(NOP, NOP, 0, 0);      chk("div_timeout", B_ERR);
    tick(); drive(NOP, NOP, 0, 1);      chk("err_sticky", B_ERR);
    chk_cnt("cnt_div");

    // hold a load-use until the 6-bit counter saturates
    for (int i = 0; i < 10; i++) begin
      tick(); drive(LW5, ADD753, 0, 0);
      chk_cnt("cnt_sat_step");
      chk("lu_hold", LUSE | B_ERR);
    end
    tick(); drive(NOP, NOP, 0, 0);      chk("sat_idle", B_ERR);
    chk_cnt("cnt_saturated");

    // asynchronous reset in the 5th MD_WAIT cycle
    tick(); drive(MUL, NOP, 0, 0);      chk("rst_mul_launch", B_ST | B_ERR);
    for (int i = 0; i < 5; i++) begin
      tick(); drive(MUL, NOP, 0, 0);    chk("rst_mul_wait", WAITSET | B_ERR);
    end
    #1 reset_n = 1'b0;
    #1;
    exp_stall = 0;
    chk("rst_async", '0);
    chk_cnt("rst_async_cnt");
    tick(); drive(MUL, LW5, 1, 1);      chk("rst_held_gated", '0);
    drive(NOP, NOP, 0, 1);
    reset_n = 1'b1;
    #1;
    chk("rst_release", '0);
    tick(); drive(NOP, NOP, 0, 1);      chk("rst_idle_ready1", '0);
    tick(); drive(NOP, NOP, 0, 1);      chk("rst_idle_ready2", '0);
    chk_cnt("rst_cnt_after");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
